// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush scheduler for the five-stage RV32 pipeline
// (IF -> ID -> EX -> MEM -> WB). It looks at the decoded instruction in ID,
// the instruction in EX and the data-memory handshake. From these it drives
// the per-stage hold lines, the ID/EX flushes and the PC redirect.
//
// Handled events, highest priority first:
//   decode error / memory timeout -> sticky HALT
//   data-memory wait state        -> freeze the whole pipeline
//   taken BNE / JAL from EX       -> redirect PC, flush ID and EX
//   load-use hazard               -> hold IF/ID, bubble EX for LOAD_LAT cycles
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   id_valid, id_instID       ID-stage instruction present / its instID
//   id_rs1, id_rs2            ID-stage source registers
//   id_error                  decoder error flag (only honoured with id_valid)
//   ex_valid, ex_instID       EX-stage instruction present / its instID
//   ex_rd                     EX-stage destination register
//   ex_redirect               EX resolved a taken BNE or a JAL
//   mem_req, mem_ready        MEM issues LW/SW / data memory completes
//   hold_if..hold_mem         freeze the corresponding stage register
//   flush_id, flush_ex        bubble the stage on the next edge
//   pc_redirect               IF loads the branch target
//   halted, halt_cause        sticky halt and its cause (1 decode, 2 timeout)
//   stall_cnt                 saturating count of cycles with hold_if=1
//
// The control outputs are combinational from the current state and inputs.
// halted, halt_cause and stall_cnt are registered. Every output is forced to
// its reset value while rst is high.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int IDW         = 8,
  parameter int ID_LW       = 40,
  parameter int ID_SW       = 45,
  parameter int ID_ADD      = 12,
  parameter int ID_BNE      = 33,
  parameter int ID_LUI      = 1,
  parameter int ID_JAL      = 30,
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [IDW-1:0] id_instID,
  input  logic [4:0]     id_rs1,
  input  logic [4:0]     id_rs2,
  input  logic           id_error,
  input  logic           ex_valid,
  input  logic [IDW-1:0] ex_instID,
  input  logic [4:0]     ex_rd,
  input  logic           ex_redirect,
  input  logic           mem_req,
  input  logic           mem_ready,
  output logic           hold_if,
  output logic           hold_id,
  output logic           hold_ex,
  output logic           hold_mem,
  output logic           flush_id,
  output logic           flush_ex,
  output logic           pc_redirect,
  output logic           halted,
  output logic [1:0]     halt_cause,
  output logic [31:0]    stall_cnt
);

  localparam logic [IDW-1:0] C_LW  = IDW'(ID_LW);
  localparam logic [IDW-1:0] C_SW  = IDW'(ID_SW);
  localparam logic [IDW-1:0] C_ADD = IDW'(ID_ADD);
  localparam logic [IDW-1:0] C_BNE = IDW'(ID_BNE);
  localparam logic [IDW-1:0] C_LUI = IDW'(ID_LUI);
  localparam logic [IDW-1:0] C_JAL = IDW'(ID_JAL);

  // Extra LSTALL cycles after the first bubble; zero means the hazard is
  // covered by the single bubble issued from RUN.
  localparam logic [2:0] SCNT_INIT = 3'(LOAD_LAT - 1);
  localparam logic       LAT_MULTI = (LOAD_LAT > 1);
  // tcnt value seen during the MEM_TIMEOUT-th consecutive wait cycle; a wait
  // in that cycle is the one that trips the halt.
  localparam logic [7:0] TCNT_LAST = 8'(MEM_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_DECODE  = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MWAIT  = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  scnt_reg, scnt_next;
  logic [7:0]  tcnt_reg, tcnt_next;
  // Remembers whether the MWAIT interrupted an LSTALL so it can resume.
  logic        ret_lstall_reg, ret_lstall_next;
  logic        halted_reg;
  logic [1:0]  cause_reg;
  logic [1:0]  cause_next;
  logic [31:0] stall_cnt_reg;

  logic uses_rs1, uses_rs2, luh;
  logic mwait, dec_err, timeout, eff_lstall;
  logic hold_if_c, hold_id_c, hold_ex_c, hold_mem_c;
  logic flush_id_c, flush_ex_c, pc_redirect_c;

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  always_comb begin
    uses_rs1 = (id_instID != C_LUI) && (id_instID != C_JAL);
    uses_rs2 = (id_instID == C_ADD) || (id_instID == C_BNE) || (id_instID == C_SW);
    luh = id_valid && ex_valid && (ex_instID == C_LW) && (ex_rd != 5'd0) &&
          ((uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd)));
  end

  assign mwait   = mem_req & ~mem_ready;
  assign dec_err = id_valid & id_error;
  assign timeout = mwait && (tcnt_reg == TCNT_LAST);
  // Once the memory wait clears, MWAIT behaves like the state it interrupted.
  assign eff_lstall = (state_reg == LSTALL) || ((state_reg == MWAIT) && ret_lstall_reg);

  // -------------------------------------------------------------------------
  // Next state and control outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    scnt_next       = scnt_reg;
    tcnt_next       = 8'd0;
    ret_lstall_next = ret_lstall_reg;
    cause_next      = cause_reg;
    hold_if_c       = 1'b0;
    hold_id_c       = 1'b0;
    hold_ex_c       = 1'b0;
    hold_mem_c      = 1'b0;
    flush_id_c      = 1'b0;
    flush_ex_c      = 1'b0;
    pc_redirect_c   = 1'b0;

    if (state_reg == HALT) begin
      hold_if_c  = 1'b1;
      hold_id_c  = 1'b1;
      hold_ex_c  = 1'b1;
      hold_mem_c = 1'b1;
    end else if (dec_err || timeout) begin
      // The entry cycle already freezes everything so the faulting
      // instruction stays where it is.
      hold_if_c  = 1'b1;
      hold_id_c  = 1'b1;
      hold_ex_c  = 1'b1;
      hold_mem_c = 1'b1;
      state_next = HALT;
      cause_next = dec_err ? CAUSE_DECODE : CAUSE_TIMEOUT;
    end else if (mwait) begin
      hold_if_c  = 1'b1;
      hold_id_c  = 1'b1;
      hold_ex_c  = 1'b1;
      hold_mem_c = 1'b1;
      tcnt_next  = tcnt_reg + 8'd1;
      state_next = MWAIT;
      if (state_reg != MWAIT) begin
        ret_lstall_next = (state_reg == LSTALL);
      end
    end else if (ex_redirect) begin
      // The dependent instruction is flushed, so any pending stall is moot.
      pc_redirect_c   = 1'b1;
      flush_id_c      = 1'b1;
      flush_ex_c      = 1'b1;
      state_next      = RUN;
      scnt_next       = 3'd0;
      ret_lstall_next = 1'b0;
    end else if (eff_lstall) begin
      hold_if_c       = 1'b1;
      hold_id_c       = 1'b1;
      flush_ex_c      = 1'b1;
      ret_lstall_next = 1'b0;
      if (scnt_reg <= 3'd1) begin
        state_next = RUN;
        scnt_next  = 3'd0;
      end else begin
        state_next = LSTALL;
        scnt_next  = scnt_reg - 3'd1;
      end
    end else begin
      state_next      = RUN;
      ret_lstall_next = 1'b0;
      if (luh) begin
        hold_if_c  = 1'b1;
        hold_id_c  = 1'b1;
        flush_ex_c = 1'b1;
        if (LAT_MULTI) begin
          state_next = LSTALL;
          scnt_next  = SCNT_INIT;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      scnt_reg       <= 3'd0;
      tcnt_reg       <= 8'd0;
      ret_lstall_reg <= 1'b0;
      halted_reg     <= 1'b0;
      cause_reg      <= 2'd0;
      stall_cnt_reg  <= 32'd0;
    end else begin
      state_reg      <= state_next;
      scnt_reg       <= scnt_next;
      tcnt_reg       <= tcnt_next;
      ret_lstall_reg <= ret_lstall_next;
      // Cause is only captured on the transition into HALT, so the first
      // cause sticks until reset.
      if ((state_reg != HALT) && (state_next == HALT)) begin
        halted_reg <= 1'b1;
        cause_reg  <= cause_next;
      end
      if (hold_if_c && (state_reg != HALT) && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs, forced to reset values while rst is asserted
  // -------------------------------------------------------------------------
  assign hold_if     = hold_if_c     & ~rst;
  assign hold_id     = hold_id_c     & ~rst;
  assign hold_ex     = hold_ex_c     & ~rst;
  assign hold_mem    = hold_mem_c    & ~rst;
  assign flush_id    = flush_id_c    & ~rst;
  assign flush_ex    = flush_ex_c    & ~rst;
  assign pc_redirect = pc_redirect_c & ~rst;
  assign halted      = halted_reg    & ~rst;
  assign halt_cause  = rst ? 2'd0  : cause_reg;
  assign stall_cnt   = rst ? 32'd0 : stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Two instances share one set of inputs: dut_a (LOAD_LAT=1) and dut_b
// (LOAD_LAT=3). Both use MEM_TIMEOUT=8. The stimulus process drives one
// cycle of inputs and pushes the hand-computed expected outputs for that
// cycle, tagged with which instance it applies to. The monitor pops one
// entry at every falling edge and compares it against that instance.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int IDW    = 8;
  localparam int LW     = 40;
  localparam int SW     = 45;
  localparam int ADD    = 12;
  localparam int BNE    = 33;
  localparam int LUI    = 1;
  localparam int JAL    = 30;
  localparam int ADDI   = 2;

  // {hold_if, hold_id, hold_ex, hold_mem, flush_id, flush_ex, pc_redirect}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LUH  = 7'b1100010;
  localparam logic [6:0] C_ALL  = 7'b1111000;
  localparam logic [6:0] C_RED  = 7'b0000111;

  logic           clk = 1'b0;
  logic           rst;
  logic           id_valid;
  logic [IDW-1:0] id_instID;
  logic [4:0]     id_rs1, id_rs2;
  logic           id_error;
  logic           ex_valid;
  logic [IDW-1:0] ex_instID;
  logic [4:0]     ex_rd;
  logic           ex_redirect;
  logic           mem_req, mem_ready;

  logic        a_hif, a_hid, a_hex, a_hmem, a_fid, a_fex, a_pcr, a_halted;
  logic [1:0]  a_cause;
  logic [31:0] a_cnt;
  logic        b_hif, b_hid, b_hex, b_hmem, b_fid, b_fex, b_pcr, b_halted;
  logic [1:0]  b_cause;
  logic [31:0] b_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .IDW(IDW), .ID_LW(LW), .ID_SW(SW), .ID_ADD(ADD), .ID_BNE(BNE),
    .ID_LUI(LUI), .ID_JAL(JAL), .LOAD_LAT(1), .MEM_TIMEOUT(8)
  ) dut_a (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_instID(id_instID), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_error(id_error), .ex_valid(ex_valid), .ex_instID(ex_instID), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .hold_if(a_hif), .hold_id(a_hid), .hold_ex(a_hex), .hold_mem(a_hmem),
    .flush_id(a_fid), .flush_ex(a_fex), .pc_redirect(a_pcr),
    .halted(a_halted), .halt_cause(a_cause), .stall_cnt(a_cnt)
  );

  pipeline_hazard_ctrl #(
    .IDW(IDW), .ID_LW(LW), .ID_SW(SW), .ID_ADD(ADD), .ID_BNE(BNE),
    .ID_LUI(LUI), .ID_JAL(JAL), .LOAD_LAT(3), .MEM_TIMEOUT(8)
  ) dut_b (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_instID(id_instID), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_error(id_error), .ex_valid(ex_valid), .ex_instID(ex_instID), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .hold_if(b_hif), .hold_id(b_hid), .hold_ex(b_hex), .hold_mem(b_hmem),
    .flush_id(b_fid), .flush_ex(b_fex), .pc_redirect(b_pcr),
    .halted(b_halted), .halt_cause(b_cause), .stall_cnt(b_cnt)
  );

  typedef struct {
    string       tag;
    bit          sel;
    logic [6:0]  ctrl;
    logic        halted;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // ---------------------------------------------------------------- monitor
  initial begin
    exp_t        e;
    logic [6:0]  act_ctrl;
    logic        act_halted;
    logic [1:0]  act_cause;
    logic [31:0] act_cnt;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel) begin
          act_ctrl   = {b_hif, b_hid, b_hex, b_hmem, b_fid, b_fex, b_pcr};
          act_halted = b_halted;
          act_cause  = b_cause;
          act_cnt    = b_cnt;
        end else begin
          act_ctrl   = {a_hif, a_hid, a_hex, a_hmem, a_fid, a_fex, a_pcr};
          act_halted = a_halted;
          act_cause  = a_cause;
          act_cnt    = a_cnt;
        end
        n_tests++;
        if (act_ctrl !== e.ctrl || act_halted !== e.halted ||
            act_cause !== e.cause || act_cnt !== e.cnt) begin
          n_fail++;
          $display("[TB] FAIL %s dut%0d: got ctrl=%b halted=%b cause=%0d cnt=%0d, expected ctrl=%b halted=%b cause=%0d cnt=%0d",
                   e.tag, e.sel, act_ctrl, act_halted, act_cause, act_cnt,
                   e.ctrl, e.halted, e.cause, e.cnt);
        end else begin
          $display("[TB] %s dut%0d: ctrl=%b halted=%b cause=%0d cnt=%0d ok",
                   e.tag, e.sel, act_ctrl, act_halted, act_cause, act_cnt);
        end
      end
    end
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d entries pending", sb.size());
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- helpers
  task automatic idle_in();
    id_valid    = 1'b0;
    id_instID   = '0;
    id_rs1      = '0;
    id_rs2      = '0;
    id_error    = 1'b0;
    ex_valid    = 1'b0;
    ex_instID   = '0;
    ex_rd       = '0;
    ex_redirect = 1'b0;
    mem_req     = 1'b0;
    mem_ready   = 1'b0;
  endtask

  // LW x<rd> in EX, ADD reading rs1=x<rd>, rs2=x1 in ID.
  task automatic set_luh(input logic [4:0] rd);
    ex_valid  = 1'b1;
    ex_instID = IDW'(LW);
    ex_rd     = rd;
    id_valid  = 1'b1;
    id_instID = IDW'(ADD);
    id_rs1    = rd;
    id_rs2    = 5'd1;
  endtask

  // Queue the expectation for the cycle whose inputs are already driven,
  // then advance to just after the next rising edge.
  task automatic cyc(input string tag, input bit sel, input logic [6:0] c,
                     input logic h, input logic [1:0] hc, input logic [31:0] n);
    exp_t e;
    e.tag = tag; e.sel = sel; e.ctrl = c; e.halted = h; e.cause = hc; e.cnt = n;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1;
    idle_in();
    @(posedge clk);
    #1;

    // Test 1: LOAD_LAT=1, single bubble. Reset cycle must mask the hazard.
    set_luh(5'd5);
    cyc("t1_rst", 1'b0, C_NONE, 1'b0, 2'd0, 32'd0);
    rst = 1'b0;
    cyc("t1_luh", 1'b0, C_LUH, 1'b0, 2'd0, 32'd0);
    ex_valid = 1'b0;
    cyc("t1_after", 1'b0, C_NONE, 1'b0, 2'd0, 32'd1);
    idle_in();
    cyc("t1_idle", 1'b0, C_NONE, 1'b0, 2'd0, 32'd1);

    // Test 2: LOAD_LAT=3, three stall cycles; no-hazard corner cases.
    rst = 1'b1;
    cyc("t2_rst", 1'b1, C_NONE, 1'b0, 2'd0, 32'd0);
    rst = 1'b0;
    set_luh(5'd5);
    cyc("t2_s1", 1'b1, C_LUH, 1'b0, 2'd0, 32'd0);
    ex_valid = 1'b0;
    cyc("t2_s2", 1'b1, C_LUH, 1'b0, 2'd0, 32'd1);
    cyc("t2_s3", 1'b1, C_LUH, 1'b0, 2'd0, 32'd2);
    cyc("t2_done", 1'b1, C_NONE, 1'b0, 2'd0, 32'd3);
    set_luh(5'd0);
    cyc("t2_x0", 1'b1, C_NONE, 1'b0, 2'd0, 32'd3);
    set_luh(5'd5);
    id_instID = IDW'(LUI);
    id_rs2    = 5'd5;
    cyc("t2_lui", 1'b1, C_NONE, 1'b0, 2'd0, 32'd3);
    set_luh(5'd7);
    id_instID = IDW'(ADDI);
    id_rs1    = 5'd1;
    id_rs2    = 5'd7;
    cyc("t2_addi", 1'b1, C_NONE, 1'b0, 2'd0, 32'd3);
    set_luh(5'd5);
    id_valid = 1'b0;
    cyc("t2_idinv", 1'b1, C_NONE, 1'b0, 2'd0, 32'd3);

    // Test 3: redirect beats a hazard in RUN, and abandons an LSTALL.
    set_luh(5'd5);
    ex_redirect = 1'b1;
    cyc("t3_red_run", 1'b1, C_RED, 1'b0, 2'd0, 32'd3);
    ex_redirect = 1'b0;
    cyc("t3_luh", 1'b1, C_LUH, 1'b0, 2'd0, 32'd3);
    ex_valid    = 1'b0;
    ex_redirect = 1'b1;
    cyc("t3_red_ls", 1'b1, C_RED, 1'b0, 2'd0, 32'd4);
    ex_redirect = 1'b0;
    cyc("t3_run", 1'b1, C_NONE, 1'b0, 2'd0, 32'd4);
    idle_in();
    cyc("t3_idle", 1'b1, C_NONE, 1'b0, 2'd0, 32'd4);
    // SW hazard through rs2 only.
    set_luh(5'd7);
    id_instID = IDW'(SW);
    id_rs1    = 5'd1;
    id_rs2    = 5'd7;
    cyc("t3_sw1", 1'b1, C_LUH, 1'b0, 2'd0, 32'd4);
    ex_valid = 1'b0;
    cyc("t3_sw2", 1'b1, C_LUH, 1'b0, 2'd0, 32'd5);
    cyc("t3_sw3", 1'b1, C_LUH, 1'b0, 2'd0, 32'd6);
    cyc("t3_sw_done", 1'b1, C_NONE, 1'b0, 2'd0, 32'd7);

    // Test 4: four memory-wait cycles inside an LSTALL, then it resumes.
    set_luh(5'd5);
    cyc("t4_luh", 1'b1, C_LUH, 1'b0, 2'd0, 32'd7);
    ex_valid = 1'b0;
    cyc("t4_ls", 1'b1, C_LUH, 1'b0, 2'd0, 32'd8);
    mem_req     = 1'b1;
    mem_ready   = 1'b0;
    ex_redirect = 1'b1;
    cyc("t4_w1", 1'b1, C_ALL, 1'b0, 2'd0, 32'd9);
    ex_redirect = 1'b0;
    cyc("t4_w2", 1'b1, C_ALL, 1'b0, 2'd0, 32'd10);
    cyc("t4_w3", 1'b1, C_ALL, 1'b0, 2'd0, 32'd11);
    cyc("t4_w4", 1'b1, C_ALL, 1'b0, 2'd0, 32'd12);
    mem_ready = 1'b1;
    cyc("t4_resume", 1'b1, C_LUH, 1'b0, 2'd0, 32'd13);
    idle_in();
    cyc("t4_done", 1'b1, C_NONE, 1'b0, 2'd0, 32'd14);

    // Test 6: decode error halt; error without id_valid is ignored.
    id_error = 1'b1;
    cyc("t6_err_inv", 1'b1, C_NONE, 1'b0, 2'd0, 32'd14);
    id_valid  = 1'b1;
    id_instID = IDW'(ADD);
    cyc("t6_err", 1'b1, C_ALL, 1'b0, 2'd0, 32'd14);
    idle_in();
    cyc("t6_h1", 1'b1, C_ALL, 1'b1, 2'd1, 32'd15);
    mem_req = 1'b1;
    cyc("t6_h2", 1'b1, C_ALL, 1'b1, 2'd1, 32'd15);
    idle_in();
    set_luh(5'd5);
    ex_redirect = 1'b1;
    cyc("t6_h3", 1'b1, C_ALL, 1'b1, 2'd1, 32'd15);
    rst = 1'b1;
    cyc("t6_rst", 1'b1, C_NONE, 1'b0, 2'd0, 32'd0);

    // Test 5: memory stuck for MEM_TIMEOUT=8 cycles -> halt cause 2.
    rst = 1'b0;
    idle_in();
    mem_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("t5_w%0d", i), 1'b1, C_ALL, 1'b0, 2'd0, 32'(i));
    end
    cyc("t5_halt", 1'b1, C_ALL, 1'b1, 2'd2, 32'd8);
    mem_req   = 1'b0;
    id_valid  = 1'b1;
    id_instID = IDW'(ADD);
    id_error  = 1'b1;
    cyc("t5_err", 1'b1, C_ALL, 1'b1, 2'd2, 32'd8);
    rst = 1'b1;
    idle_in();
    cyc("t5_rst", 1'b1, C_NONE, 1'b0, 2'd0, 32'd0);
    rst = 1'b0;
    cyc("t5_run", 1'b1, C_NONE, 1'b0, 2'd0, 32'd0);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 4; i++) begin
      if (sb.size() != 0) @(posedge clk);
    end
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush scheduler for the RV32 pipeline (IF → ID → EX → MEM → WB).
- Watches the decoded instruction in ID, the instruction in EX and the data-memory handshake.
- Drives the `hold` inputs of every stage plus flush and PC-redirect controls.
- Resolves load-use hazards, taken BNE/JAL redirects, data-memory wait states and fatal decode errors (sticky halt).

Parameters:
- IDW, 8, width of instID (matches `InstIDDepth`).
- ID_LW / ID_SW / ID_ADD / ID_BNE / ID_LUI / ID_JAL, the `defines.v` codes (ID_ADDI=2, ID_BNE=33), instruction ID codes compared against.
- LOAD_LAT, 1, number of bubble cycles inserted on a load-use hazard (1..7).
- MEM_TIMEOUT, 255, maximum consecutive wait cycles on the data memory before a halt (1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_instID  in  IDW  instID of the ID-stage instruction.
- id_rs1, id_rs2  in  5  source registers of the ID-stage instruction.
- id_error  in  1  decoder error flag.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_instID  in  IDW  instID in EX.
- ex_rd  in  5  destination register in EX.
- ex_redirect  in  1  EX resolved a taken BNE or a JAL.
- mem_req  in  1  MEM stage is issuing an LW/SW.
- mem_ready  in  1  data memory completes the access this cycle.
- hold_if, hold_id, hold_ex, hold_mem  out  1  freeze the stage register.
- flush_id, flush_ex  out  1  replace the stage contents with a bubble on the next edge.
- pc_redirect  out  1  IF loads the branch target.
- halted  out  1  sticky halt.
- halt_cause  out  2  0 none, 1 decode error, 2 memory timeout.
- stall_cnt  out  32  saturating count of cycles with hold_if=1.

Behaviour:
- States: RUN, LSTALL, MWAIT, HALT. Reset → RUN, stall counter (scnt) = 0, timeout counter (tcnt) = 0.
- Output values at reset: holds=0, flushes=0, pc_redirect=0, halted=0, halt_cause=0, stall_cnt=0.
- Control outputs are combinational from the current state and current inputs, so they take effect on the next clock edge. halted, halt_cause and stall_cnt are registered.
- Source usage:
  - uses_rs1 = every ID except LUI and JAL.
  - uses_rs2 = ADD, BNE, SW.
- Load-use hazard (luh) = id_valid & ex_valid & ex_instID==ID_LW & ex_rd!=0 & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)).
- Per-cycle priority: HALT > MWAIT > redirect > luh > normal.
- HALT:
  - Entered on id_valid&id_error (cause 1) or a memory timeout (cause 2).
  - All four holds = 1, flushes = 0, pc_redirect = 0, halted = 1.
  - Exit only via rst. The first cause latched wins.
- MWAIT condition: mem_req & !mem_ready.
  - In RUN, LSTALL or MWAIT this asserts all four holds and suppresses flushes and pc_redirect.
  - tcnt increments each such cycle and clears when the condition drops.
  - tcnt reaching MEM_TIMEOUT → HALT on the next edge.
  - An LSTALL interrupted by MWAIT resumes with its scnt unchanged.
- Redirect: ex_redirect in RUN/LSTALL (not MWAIT) → pc_redirect=1, flush_id=1, flush_ex=1 for that cycle.
  - A pending LSTALL is abandoned: go to RUN, scnt=0, because the dependent instruction is being flushed.
- luh in RUN (no redirect, no MWAIT):
  - hold_if=1, hold_id=1, flush_ex=1.
  - Go to LSTALL with scnt=LOAD_LAT-1. If LOAD_LAT=1, stay in RUN.
- LSTALL:
  - hold_if=1, hold_id=1, flush_ex=1.
  - scnt decrements; at scnt==0 return to RUN.
  - luh is not re-evaluated while in LSTALL.
- Normal: all outputs 0.
- stall_cnt increments when hold_if=1 and saturates at 0xFFFFFFFF. It does not count while halted.
- id_error with id_valid=0 is ignored.
- rst mid-stall clears all state immediately. Outputs hold their reset values during the rst cycle.

Test Plan:
1. ex=LW x5, id=ADD x6,x5,x1 (valid), LOAD_LAT=1 → exactly 1 cycle of hold_if=hold_id=flush_ex=1, then all 0; stall_cnt=1.
2. Same hazard with LOAD_LAT=3 → 3 consecutive stall cycles. LW with rd=x0, and LUI in ID reading the rd field → no stall.
3. LSTALL (LOAD_LAT=3) with ex_redirect in its 2nd cycle → pc_redirect=flush_id=flush_ex=1 that cycle, RUN next, no further holds.
4. mem_req=1, mem_ready=0 for 4 cycles during an LSTALL → all holds=1 for 4 cycles, then the LSTALL resumes and finishes its remaining cycles.
5. MEM_TIMEOUT=8, mem_ready stuck at 0 → halted=1, halt_cause=2 on the following edge. A later id_error leaves the cause at 2. rst clears everything.
6. id_valid=1 & id_error=1 in RUN → halted=1, halt_cause=1, all holds=1 persistently. id_error with id_valid=0 → no effect.
